mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have the port `clk` (input, 1 bit): sole clock; all state updates on its rising edge.
REQ-002 SHALL have the port `reset` (input, 1 bit): synchronous, active-high reset.
REQ-003 SHALL have the port `req_valid` (input, 1 bit): CPU presents a load/store request.
REQ-004 SHALL have the port `req_ready` (output, 1 bit): unit can accept a request this cycle.
REQ-005 SHALL have the port `req_write` (input, 1 bit): 1 means store, 0 means load.
REQ-006 SHALL have the port `req_size` (input, 2 bits): 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have the port `req_unsigned` (input, 1 bit): for loads, 1 zero-extends and 0 sign-extends.
REQ-008 SHALL have the port `req_addr` (input, 32 bits): byte address.
REQ-009 SHALL have the port `req_wdata` (input, 32 bits): store data, right-justified.
REQ-010 SHALL have the port `resp_valid` (output, 1 bit): one-cycle completion pulse.
REQ-011 SHALL have the port `resp_rdata` (output, 32 bits): extended load result; 0 for stores and errors.
REQ-012 SHALL have the port `resp_err` (output, 1 bit): misaligned or illegal request; valid only with `resp_valid`.
REQ-013 SHALL have the port `mem_read` (output, 1 bit): read strobe to word-addressed data memory.
REQ-014 SHALL have the port `mem_write` (output, 1 bit): write strobe; memory writes on the rising edge of `clk`.
REQ-015 SHALL have the port `mem_addr` (output, 32 bits): word-aligned address, bits [1:0] always 00.
REQ-016 SHALL have the port `mem_wdata` (output, 32 bits): full word to write.
REQ-017 SHALL have the port `mem_rdata` (input, 32 bits): combinational read data, valid in the same cycle as `mem_read`.

Function
REQ-018 SHALL implement a finite state machine with states IDLE, READ, WRITE and RESP; `req_ready` SHALL equal 1 only in IDLE.
REQ-019 SHALL accept a request when `req_valid` and `req_ready` are both 1 in the same cycle (cycle A), registering all `req_*` fields; no input is sampled outside cycle A.
REQ-020 SHALL drive `mem_addr` as {addr[31:2],2'b00} from the registered address, holding it stable from A+1 until the return to IDLE.
REQ-021 SHALL use little-endian byte lanes: byte k = bits [8k+7:8k], with k = addr[1:0]; halfword lanes are selected by addr[1].
REQ-022 Load: SHALL be in READ at A+1 with `mem_read`=1, capture `mem_rdata` at the end of A+1, and be in RESP at A+2 with `resp_valid`=1 and the extended lane data on `resp_rdata`.
REQ-023 Word store: SHALL be in WRITE at A+1 with `mem_write`=1 and `mem_wdata`=`req_wdata`, then be in RESP at A+2.
REQ-024 Byte or halfword store: SHALL perform read-modify-write — READ at A+1, capture the word, WRITE at A+2 with only the addressed lane(s) replaced by the low bits of `req_wdata`, then RESP at A+3.
REQ-025 Misaligned request (halfword with addr[0]=1, word with addr[1:0]≠00) or `req_size`=11: SHALL go IDLE→RESP at A+1 with `resp_err`=1 and `mem_read`=`mem_write`=0 throughout.
REQ-026 SHALL hold `resp_valid` for exactly one cycle; RESP→IDLE is unconditional (no backpressure), so the earliest next acceptance is the cycle after RESP.
REQ-027 SHALL never assert `mem_read` and `mem_write` in the same cycle.
REQ-028 Outside the READ and WRITE states, `mem_read`, `mem_write` and `mem_wdata` SHALL be 0.

Reset
REQ-029 While `reset`=1, the unit SHALL combinationally force `mem_read`=`mem_write`=0; at the next edge it SHALL move to IDLE.
REQ-030 Reset values SHALL be: state IDLE; `req_ready`=1 (first cycle after reset); `resp_valid`=`resp_err`=0; `resp_rdata`=`mem_addr`=`mem_wdata`=0.
REQ-031 Reset mid-operation SHALL abandon the request: no memory write and no `resp_valid` for it.

Configuration
REQ-032 Macro MAU_MISALIGN_TRAP_EN defined: misalignment detection per REQ-025 SHALL be active.
REQ-033 MAU_MISALIGN_TRAP_EN undefined: the unit SHALL ignore the offending low address bits (halfword uses addr[1], word uses lane 0), perform a normal access, and tie `resp_err`=0 except for `req_size`=11, which still errors.

Verification
REQ-034 Store word 0xDEADBEEF at address 0x10 → `mem_write`=1 at A+1 with `mem_addr`=0x10; `resp_valid` at A+2; memory word 4 = 0xDEADBEEF.
REQ-035 With word 0x11223344 at address 0x20, store byte 0xAB at address 0x22 → `mem_read` at A+1, `mem_write` at A+2 with `mem_wdata`=0x11AB3344, `resp_valid` at A+3.
REQ-036 With word 0x80FF7F01 at address 0x30: load byte signed at 0x32 → 0xFFFFFFFF; load byte unsigned at 0x32 → 0x000000FF; load halfword signed at 0x32 → 0xFFFF80FF; load byte at 0x30 → 0x00000001.
REQ-037 Load word at 0x13 with the macro defined → `resp_valid`=`resp_err`=1 at A+1, no memory strobe; with the macro undefined → normal word read of address 0x10.
REQ-038 Assert `reset` during the WRITE cycle of a byte store → `mem_write`=0, memory unchanged, no `resp_valid`, `req_ready`=1 after reset.
REQ-039 Back-to-back requests with `req_valid` held high → `req_ready` low except in IDLE; each response appears exactly once, in request order.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a CPU request port and a
// word-addressed data memory with combinational read data.
// Byte/halfword stores use read-modify-write; loads are sign/zero extended.
// Build option: define MAU_MISALIGN_TRAP_EN to report misaligned halfword/word
// requests as errors; otherwise the offending low address bits are ignored
// and only req_size=11 errors.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        err_q;

    logic        accept;
    logic        bad_req;

    // Extract the addressed lane from a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {(uns ? 24'h000000 : {24{b[7]}}), b};
            2'b01:   r = {(uns ? 16'h0000 : {16{h[15]}}), h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic [31:0] d);
        logic [31:0] m;
        m = w;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    m[7:0]   = d[7:0];
                    2'd1:    m[15:8]  = d[7:0];
                    2'd2:    m[23:16] = d[7:0];
                    default: m[31:24] = d[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) m[31:16] = d[15:0];
                else        m[15:0]  = d[15:0];
            end
            default: m = d;
        endcase
        return m;
    endfunction

    // Classify the incoming request; without the trap option only size 11 errors.
    always_comb begin
`ifdef MAU_MISALIGN_TRAP_EN
        bad_req = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        bad_req = (req_size == 2'b11);
`endif
    end

    assign mem_addr = {addr_q[31:2], 2'b00};

    // Next-state decode and all strobes/response outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (bad_req)                             state_d = RESP;
                    else if (req_write && req_size == 2'b10) state_d = WRITE;
                    else                                     state_d = READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                state_d  = write_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_wdata = store_merge(word_q, size_q, addr_q[1:0], wdata_q);
                state_d   = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!write_q && !err_q)
                    resp_rdata = load_extend(word_q, size_q, addr_q[1:0], uns_q);
                state_d = IDLE;
            end
        endcase
        // Reset must block memory strobes within the same cycle, not only after the edge.
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_wdata = '0;
        end
    end

    // State register, request capture on acceptance, read-data capture in READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= bad_req;
            end
            if (state_q == READ)
                word_q <= mem_rdata;
        end
    end

endmodule
